// File: rtl/rvfi_commit_buffer.sv
// RVFI commit buffer: compacts multi-port retire/trap records into a FIFO and
// replays them one per cycle in program order, tagged with a retirement order number.

package rvfi_pkg;
  typedef struct packed {
    logic        valid;
    logic        trap;
    logic [31:0] insn;
    logic [63:0] pc_rdata;
    logic [63:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [63:0] rd_wdata;
  } rvfi_instr_t;
endpackage

module rvfi_commit_buffer
  import rvfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  rvfi_instr_t              rvfi_i [NR_COMMIT_PORTS],
  output rvfi_instr_t              rvfi_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [63:0]              order_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [31:0]              drop_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  rvfi_instr_t   mem_r [DEPTH];
  logic [PW-1:0] wp_r;
  logic [PW-1:0] rp_r;
  logic [CW-1:0] count_r;
  logic [63:0]   order_r;
  logic          overflow_r;
  logic [31:0]   drop_cnt_r;

  logic [CW-1:0] free_s;
  logic [CW-1:0] pushed_s;
  logic [31:0]   dropped_s;
  logic          we_s    [NR_COMMIT_PORTS];
  logic [PW-1:0] waddr_s [NR_COMMIT_PORTS];
  logic          pop_s;
  logic [32:0]   drop_sum_s;
  logic [31:0]   drop_cnt_next_s;

  // Compact active ports into consecutive slots; space is judged before any same-cycle pop.
  always_comb begin
    free_s    = CNT_DEPTH - count_r;
    pushed_s  = '0;
    dropped_s = 32'd0;
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      we_s[i]    = 1'b0;
      waddr_s[i] = wp_r + pushed_s[PW-1:0];
      if (rvfi_i[i].valid | rvfi_i[i].trap) begin
        if (pushed_s < free_s) begin
          we_s[i]  = 1'b1;
          pushed_s = pushed_s + CNT_ONE;
        end else begin
          dropped_s = dropped_s + 32'd1;
        end
      end else begin
        we_s[i] = 1'b0;
      end
    end
    pop_s           = (count_r != '0) & ready_i;
    drop_sum_s      = {1'b0, drop_cnt_r} + {1'b0, dropped_s};
    drop_cnt_next_s = drop_sum_s[32] ? 32'hFFFF_FFFF : drop_sum_s[31:0];
  end

  // Record storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        mem_r[j] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
        if (we_s[i]) begin
          mem_r[waddr_s[i]] <= rvfi_i[i];
        end
      end
    end
  end

  // Pointers and occupancy; full/empty come from count_r alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_r    <= '0;
      rp_r    <= '0;
      count_r <= '0;
    end else begin
      wp_r    <= wp_r + pushed_s[PW-1:0];
      rp_r    <= rp_r + {{(PW-1){1'b0}}, pop_s};
      count_r <= count_r + pushed_s - {{PW{1'b0}}, pop_s};
    end
  end

  // Retirement order counts only valid records; trap-only records leave it unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      order_r <= 64'd0;
    end else if (pop_s && mem_r[rp_r].valid) begin
      order_r <= order_r + 64'd1;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 32'd0;
    end else begin
      if (dropped_s != 32'd0) begin
        overflow_r <= 1'b1;
      end
      drop_cnt_r <= drop_cnt_next_s;
    end
  end

  // Head record is read combinationally and forced to zero when empty.
  always_comb begin
    valid_o = (count_r != '0);
    if (valid_o) begin
      rvfi_o = mem_r[rp_r];
    end else begin
      rvfi_o = '0;
    end
  end

  assign order_o    = order_r;
  assign count_o    = count_r;
  assign overflow_o = overflow_r;
  assign drop_cnt_o = drop_cnt_r;

endmodule

// File: tb/tb_rvfi_commit_buffer.sv
// Scoreboard bench for rvfi_commit_buffer: a queue model tracks accepted records,
// drops and retirement order, and every cycle's outputs are compared against it.

module tb_rvfi_commit_buffer;
  import rvfi_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 8;

  logic                   clk;
  logic                   rst_n;
  rvfi_instr_t            rvfi_s [NR];
  rvfi_instr_t            rvfi_o;
  logic                   valid_o;
  logic                   ready;
  logic [63:0]            order_o;
  logic [$clog2(DEPTH):0] count_o;
  logic                   overflow_o;
  logic [31:0]            drop_cnt_o;

  int checks   = 0;
  int failures = 0;

  rvfi_instr_t q[$];
  logic [63:0] m_order;
  logic        m_ovf;
  logic [31:0] m_drop;
  int          peak;

  rvfi_commit_buffer #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rvfi_i     (rvfi_s),
    .rvfi_o     (rvfi_o),
    .valid_o    (valid_o),
    .ready_i    (ready),
    .order_o    (order_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rvfi_instr_t mk(input logic v, input logic t, input logic [63:0] pc);
    rvfi_instr_t r;
    r          = '0;
    r.valid    = v;
    r.trap     = t;
    r.pc_rdata = pc;
    r.pc_wdata = pc + 64'd4;
    r.insn     = pc[31:0] ^ 32'h0000_0013;
    r.rd_addr  = pc[6:2];
    r.rd_wdata = ~pc;
    return r;
  endfunction

  function automatic rvfi_instr_t idle();
    return '0;
  endfunction

  // One clock: drive inputs, compare outputs at negedge, then advance the model.
  task automatic step(input logic rdy, input rvfi_instr_t r0, input rvfi_instr_t r1);
    int          free;
    logic        hs;
    rvfi_instr_t exp_head;
    rvfi_s[0] = r0;
    rvfi_s[1] = r1;
    ready     = rdy;
    @(negedge clk);
    exp_head = (q.size() != 0) ? q[0] : '0;
    check("valid", 256'(valid_o), 256'(q.size() != 0));
    check("count", 256'(count_o), 256'(q.size()));
    check("order", 256'(order_o), 256'(m_order));
    check("overflow", 256'(overflow_o), 256'(m_ovf));
    check("drop_cnt", 256'(drop_cnt_o), 256'(m_drop));
    check("head", 256'(rvfi_o), 256'(exp_head));
    hs   = (q.size() != 0) && rdy;
    free = DEPTH - q.size();
    for (int i = 0; i < NR; i++) begin
      if (rvfi_s[i].valid | rvfi_s[i].trap) begin
        if (free > 0) begin
          q.push_back(rvfi_s[i]);
          free--;
        end else begin
          m_drop = (m_drop == 32'hFFFF_FFFF) ? m_drop : m_drop + 32'd1;
          m_ovf  = 1'b1;
        end
      end
    end
    if (hs) begin
      if (exp_head.valid) m_order = m_order + 64'd1;
      void'(q.pop_front());
    end
    if (q.size() > peak) peak = q.size();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b1, idle(), idle());
    check("drain_done", 256'(q.size()), 256'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    ready     = 1'b1;
    rvfi_s[0] = '0;
    rvfi_s[1] = '0;
    q.delete();
    m_order = 64'd0;
    m_ovf   = 1'b0;
    m_drop  = 32'd0;
    peak    = 0;
    #1;
    check("rst_count", 256'(count_o), 256'(0));
    check("rst_valid", 256'(valid_o), 256'(0));
    check("rst_rvfi", 256'(rvfi_o), 256'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle with ready high.
    for (int i = 0; i < 20; i++) step(1'b1, idle(), idle());

    // Both ports valid, three cycles, drained in PC order.
    peak = 0;
    for (int c = 0; c < 3; c++)
      step(1'b1, mk(1'b1, 1'b0, 64'h8000_0000 + 64'(c * 8)),
                 mk(1'b1, 1'b0, 64'h8000_0004 + 64'(c * 8)));
    drain();
    check("peak4", 256'(peak), 256'(4));
    check("order6", 256'(order_o), 256'(6));
    check("no_ovf", 256'(overflow_o), 256'(0));

    // Compaction and trap-only records.
    step(1'b1, idle(), mk(1'b1, 1'b0, 64'h100));
    step(1'b1, mk(1'b0, 1'b1, 64'h104), idle());
    step(1'b1, mk(1'b1, 1'b0, 64'h108), idle());
    drain();
    check("order_trap", 256'(order_o), 256'(8));

    // Fill with ready low, then overflow by two.
    for (int c = 0; c < 5; c++)
      step(1'b0, mk(1'b1, 1'b0, 64'h2000 + 64'(c * 8)),
                 mk(1'b1, 1'b0, 64'h2004 + 64'(c * 8)));
    step(1'b0, idle(), idle());
    check("ovf_set", 256'(overflow_o), 256'(1));
    check("drop2", 256'(drop_cnt_o), 256'(2));
    check("full8", 256'(count_o), 256'(8));
    drain();
    check("ovf_sticky", 256'(overflow_o), 256'(1));

    // count=7 with both ports and a simultaneous pop.
    for (int c = 0; c < 3; c++)
      step(1'b0, mk(1'b1, 1'b0, 64'h3000 + 64'(c * 8)),
                 mk(1'b1, 1'b0, 64'h3004 + 64'(c * 8)));
    step(1'b0, mk(1'b1, 1'b0, 64'h3018), idle());
    check("cnt7", 256'(count_o), 256'(7));
    step(1'b1, mk(1'b1, 1'b0, 64'h3020), mk(1'b1, 1'b0, 64'h3024));
    check("cnt7_hold", 256'(count_o), 256'(7));
    check("drop3", 256'(drop_cnt_o), 256'(3));
    // Hold check while stalled.
    step(1'b0, idle(), idle());
    step(1'b0, idle(), idle());

    // Build count=5 mid-drain, then async reset.
    step(1'b1, idle(), idle());
    step(1'b1, idle(), idle());
    check("cnt5", 256'(count_o), 256'(5));
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 256'(count_o), 256'(0));
    check("arst_valid", 256'(valid_o), 256'(0));
    check("arst_order", 256'(order_o), 256'(0));
    check("arst_ovf", 256'(overflow_o), 256'(0));
    check("arst_drop", 256'(drop_cnt_o), 256'(0));
    q.delete();
    m_order = 64'd0;
    m_ovf   = 1'b0;
    m_drop  = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, mk(1'b1, 1'b0, 64'h4000), idle());
    check("post_rst_order", 256'(order_o), 256'(0));
    check("post_rst_pc", 256'(rvfi_o.pc_rdata), 256'(64'h4000));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
